// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared types and constants for the external memory bus arbiter.
//             - arb_state_t  : arbiter FSM states
//             - GRANT_*      : one-hot grant vector encodings
//             - DEFAULT_TIMEOUT_CYCLES : default no-ack watchdog limit
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : arb_watchdog
//  Purpose  : No-ack watchdog for the bus arbiter. Counts granted cycles
//             without an acknowledge and flags expiry when the count reaches
//             TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 removes the counter entirely.
//  Ports    : clk      - clock
//             ctr_rst  - asynchronous active-high reset
//             granted  - bus is currently owned by a requester
//             ack      - bus acknowledge this cycle
//             expired  - combinational: owner has waited TIMEOUT_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
module arb_watchdog
    import arb_pkg::*;
#(
    parameter int CNT_BITS       = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic ctr_rst,
    input  logic granted,
    input  logic ack,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_enabled
            localparam logic [CNT_BITS-1:0] LIMIT = CNT_BITS'(TIMEOUT_CYCLES);

            logic [CNT_BITS-1:0] count;

            // Held at zero outside ownership, so every new grant starts from 0.
            // Saturates at all-ones rather than wrapping.
            always_ff @(posedge clk or posedge ctr_rst) begin
                if (ctr_rst) begin
                    count <= '0;
                end else if (!granted || ack) begin
                    count <= '0;
                end else if (count != '1) begin
                    count <= count + 1'b1;
                end
            end

            assign expired = granted && (count == LIMIT);
        end else begin : g_disabled
            assign expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Round-robin arbiter sharing one external memory bus between the
//             instruction-cache (req0) and data-cache (req1) miss controllers.
//             A grant is held while the owner keeps re/wr asserted; each
//             ownership ends with one quiet RELEASE cycle. A no-ack watchdog
//             forcibly releases a stuck owner and sets a sticky timeout flag.
//  Ports    : clk, ctr_rst (async, active-high)
//             req{0,1}_addr/re/wr/wdata  - requester side inputs
//             req{0,1}_rdata/ack         - responses routed to the owner only
//             mem_addr/re/wr/wdata       - bus drive from the owner
//             mem_rdata/ack              - bus responses
//             grant   - one-hot owner indication
//             timeout - sticky watchdog error flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 ctr_rst,
    input  logic [31:0]          req0_addr,
    input  logic                 req0_re,
    input  logic                 req0_wr,
    input  logic [WORD_SIZE-1:0] req0_wdata,
    output logic [WORD_SIZE-1:0] req0_rdata,
    output logic                 req0_ack,
    input  logic [31:0]          req1_addr,
    input  logic                 req1_re,
    input  logic                 req1_wr,
    input  logic [WORD_SIZE-1:0] req1_wdata,
    output logic [WORD_SIZE-1:0] req1_rdata,
    output logic                 req1_ack,
    output logic [31:0]          mem_addr,
    output logic                 mem_re,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [1:0]           grant,
    output logic                 timeout
);

    arb_state_t state;
    logic       last_grant;     // 0: req0 owned last, 1: req1 owned last
    logic [1:0] seen;           // requests as sampled on the previous edge
    logic [1:0] active;
    logic [1:0] candidates;
    logic       granted;
    logic       expired;

    assign active     = {req1_re | req1_wr, req0_re | req0_wr};
    // A request must be present on two consecutive edges to be arbitrated;
    // this gives the fixed one-cycle sampling stage ahead of the grant.
    assign candidates = seen & active;
    assign granted    = (state == GRANT0) || (state == GRANT1);

    arb_watchdog #(
        .CNT_BITS       (CNT_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .ctr_rst (ctr_rst),
        .granted (granted),
        .ack     (mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge ctr_rst) begin
        if (ctr_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            seen       <= 2'b00;
            timeout    <= 1'b0;
        end else begin
            seen <= active;
            case (state)
                IDLE: begin
                    case (candidates)
                        2'b01:   state <= GRANT0;
                        2'b10:   state <= GRANT1;
                        2'b11:   state <= last_grant ? GRANT0 : GRANT1;
                        default: state <= IDLE;
                    endcase
                end
                GRANT0: begin
                    if (expired) begin
                        state      <= RELEASE;
                        last_grant <= 1'b0;
                        timeout    <= 1'b1;
                    end else if (!active[0]) begin
                        state      <= RELEASE;
                        last_grant <= 1'b0;
                    end
                end
                GRANT1: begin
                    if (expired) begin
                        state      <= RELEASE;
                        last_grant <= 1'b1;
                        timeout    <= 1'b1;
                    end else if (!active[1]) begin
                        state      <= RELEASE;
                        last_grant <= 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and response routing follow the owner; everything is zero in
    // IDLE/RELEASE, so an asynchronous reset silences the bus immediately.
    always_comb begin
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        req0_rdata = '0;
        req0_ack   = 1'b0;
        req1_rdata = '0;
        req1_ack   = 1'b0;
        grant      = GRANT_NONE;
        case (state)
            GRANT0: begin
                mem_addr   = req0_addr;
                mem_wdata  = req0_wdata;
                mem_wr     = req0_wr;
                mem_re     = req0_re & ~req0_wr;
                req0_ack   = mem_ack;
                req0_rdata = mem_rdata;
                grant      = GRANT_REQ0;
            end
            GRANT1: begin
                mem_addr   = req1_addr;
                mem_wdata  = req1_wdata;
                mem_wr     = req1_wr;
                mem_re     = req1_re & ~req1_wr;
                req1_ack   = mem_ack;
                req1_rdata = mem_rdata;
                grant      = GRANT_REQ1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between two cache miss controllers: requester 0 is the instruction cache, requester 1 is the data cache.
- Round-robin arbitration. A grant is locked for a whole transaction, e.g. a multi-beat line fill held by continuous re.
- Includes a no-ack watchdog.
- Sits between the miss controllers' ext_* ports and the memory model/bus.

Parameters:
- WORD_SIZE, 32, data bus width in bits
- TIMEOUT_CYCLES, 255, granted cycles without mem_ack before forced release; 0 disables the watchdog
- CNT_BITS, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  clock
- ctr_rst  in  1  reset, asynchronous, active-high
- req0_addr  in  32  requester 0 address
- req0_re  in  1  requester 0 read request
- req0_wr  in  1  requester 0 write request
- req0_wdata  in  WORD_SIZE  requester 0 write data
- req0_rdata  out  WORD_SIZE  read data to requester 0
- req0_ack  out  1  mem_ack routed to requester 0
- req1_addr, req1_re, req1_wr, req1_wdata, req1_rdata, req1_ack  same as req0_*, for requester 1
- mem_addr  out  32  bus address
- mem_re  out  1  bus read strobe
- mem_wr  out  1  bus write strobe
- mem_wdata  out  WORD_SIZE  bus write data
- mem_rdata  in  WORD_SIZE  bus read data
- mem_ack  in  1  bus acknowledge
- grant  out  2  one-hot: bit0 = req0 owns bus, bit1 = req1 owns bus
- timeout  out  1  sticky watchdog error flag

Behaviour:
- States: IDLE, GRANT0, GRANT1, RELEASE. State, last_grant, watchdog counter and timeout are registered on posedge clk.
- ctr_rst is asynchronous. On assertion, including mid-transaction:
  - state=IDLE, last_grant=1 (req0 has priority first), counter=0, timeout=0.
  - All outputs 0 immediately.
- A requester is "active" when reqN_re | reqN_wr.
- IDLE:
  - Only req0 active -> GRANT0. Only req1 active -> GRANT1.
  - Both active -> the requester other than last_grant wins.
  - None active -> stay in IDLE.
  - Bus outputs are 0.
- Grant latency: a request sampled at edge N gives grant and bus drive visible after edge N+1.
- GRANTn (combinational mux from owner n):
  - mem_addr=reqn_addr, mem_wdata=reqn_wdata, mem_wr=reqn_wr.
  - mem_re=reqn_re & ~reqn_wr: write wins when both are asserted.
  - reqn_ack=mem_ack and reqn_rdata=mem_rdata. The non-owner's ack and rdata are 0.
  - grant[n]=1.
- Lock: stay in GRANTn while requester n is active. Requests from the other side are ignored meanwhile.
- Owner drops re and wr -> RELEASE; last_grant<=n.
- RELEASE: one idle bus cycle with all outputs 0, then IDLE. This guarantees a quiet gap between owners.
- Back-to-back: a requester that stays active after its own release can win again only if the other side is inactive in IDLE.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter clears on entry to GRANTn and on every cycle with mem_ack=1.
  - It increments every GRANT cycle without ack.
  - At counter==TIMEOUT_CYCLES: next state=RELEASE, last_grant<=n, timeout<=1 (sticky until ctr_rst).
  - The requester sees no ack. Recovery is the requester's job.
  - Counter saturates; no wrap.
- mem_ack outside GRANT states is ignored and routed nowhere.
- Illegal state encoding -> IDLE on the next edge.

Decomposition:
- Shared package arb_pkg holds:
  - arb_state_t enum: IDLE, GRANT0, GRANT1, RELEASE.
  - GRANT_NONE/GRANT_REQ0/GRANT_REQ1 one-hot constants.
  - Default TIMEOUT_CYCLES constant.
- One sub-module is natural: arb_watchdog. It holds the counter with clear/increment/saturate and raises an expired pulse. Parameters: CNT_BITS, TIMEOUT_CYCLES.
- Muxing and the FSM stay in the top.

Test Plan:
- Reset release, req0_re=1 with req0_addr=0x1040 -> grant=01 two edges later, mem_addr=0x1040, mem_re=1, req1_ack=0.
- req0 holds re across 16 mem_ack beats while req1_wr=1 from beat 2 -> grant stays 01 for all 16 beats; after req0 drops: one RELEASE cycle with all mem_* 0, then grant=10, mem_wr=1.
- req0 and req1 both assert in the same cycle after reset -> req0 granted first. After it completes, simultaneous re-request -> req1 granted (round-robin).
- req1_wr=1 and req1_re=1 together, mem_wdata=0xDEADBEEF -> mem_wr=1, mem_re=0, mem_wdata=0xDEADBEEF.
- TIMEOUT_CYCLES=4, req0_re held, mem_ack never asserted -> after 4 granted cycles: RELEASE, timeout=1 and stays 1 across later normal transactions until ctr_rst.
- ctr_rst pulsed mid line fill (grant=10) -> grant, mem_re and timeout are 0 immediately without waiting for a clock edge. After release, req0 wins a simultaneous request.
